// File: rtl/vga_scan_ctrl.sv
// Raster scan sequencer: pixel counters, sync/blank/DE decode, and a one-per-line
// prefetch req/ack handshake with a sticky underrun flag.
module vga_scan_ctrl #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          SYNC_POL = 1'b0,
  parameter int unsigned CW       = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic [CW-1:0] px_x,
  output logic [CW-1:0] px_y,
  output logic          line_start,
  output logic          frame_start,
  output logic          line_req,
  output logic [CW-1:0] line_req_y,
  input  logic          line_ack,
  output logic          underrun,
  input  logic          underrun_clr
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] X_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] Y_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] X_ACT    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] Y_ACT    = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_START = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_START = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic {IDLE, REQ} req_state_t;
  req_state_t state;

  logic          x_wrap, y_wrap;
  logic [CW-1:0] nx, ny, next_line;
  logic          hs_act, vs_act, req_fire, abandon, und_set;

  // Outputs are registered from the next counter values so they always
  // describe the position reported alongside them.
  always_comb begin
    x_wrap    = (px_x == X_LAST);
    y_wrap    = (px_y == Y_LAST);
    nx        = x_wrap ? '0 : px_x + 1'b1;
    next_line = y_wrap ? '0 : px_y + 1'b1;
    ny        = x_wrap ? next_line : px_y;
    hs_act    = (nx >= HS_START) && (nx < HS_END);
    vs_act    = (ny >= VS_START) && (ny < VS_END);
    req_fire  = en && (nx == X_ACT) && (next_line < Y_ACT);
    abandon   = en && (nx == '0) && (ny == line_req_y);
    und_set   = (state == REQ) && !line_ack && abandon;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      px_x        <= X_LAST;
      px_y        <= Y_LAST;
      hsync       <= !SYNC_POL;
      vsync       <= !SYNC_POL;
      de          <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      state       <= IDLE;
      line_req    <= 1'b0;
      line_req_y  <= '0;
      underrun    <= 1'b0;
    end else begin
      if (en) begin
        px_x        <= nx;
        px_y        <= ny;
        hsync       <= SYNC_POL ? hs_act : !hs_act;
        vsync       <= SYNC_POL ? vs_act : !vs_act;
        de          <= (nx < X_ACT) && (ny < Y_ACT);
        line_start  <= (nx == '0);
        frame_start <= (nx == '0) && (ny == '0);
      end else begin
        line_start  <= 1'b0;
        frame_start <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (req_fire) begin
            state      <= REQ;
            line_req   <= 1'b1;
            line_req_y <= next_line;
          end
        end
        REQ: begin
          // Ack takes priority over an abandon on the same edge.
          if (line_ack || abandon) begin
            state    <= IDLE;
            line_req <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          line_req <= 1'b0;
        end
      endcase

      if (und_set)
        underrun <= 1'b1;
      else if (underrun_clr)
        underrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// Self-checking bench for vga_scan_ctrl using a reduced raster and a linear
// scan-position reference model.
module tb_vga_scan_ctrl;

  localparam int HA = 16, HF = 4, HS = 6, HB = 4;
  localparam int VA = 12, VF = 2, VS = 2, VB = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0, line_ack = 1'b0, underrun_clr = 1'b0;
  logic       hsync, vsync, de, line_start, frame_start, line_req, underrun;
  logic [9:0] px_x, px_y, line_req_y;

  int checks = 0;
  int errors = 0;

  // Reference model: linear position within the frame plus handshake state.
  int m_t, m_req_y;
  logic m_req, m_und, m_ls, m_fs;

  vga_scan_ctrl #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(1'b0), .CW(10)
  ) dut (
    .clk(clk), .rst(rst), .en(en),
    .hsync(hsync), .vsync(vsync), .de(de),
    .px_x(px_x), .px_y(px_y),
    .line_start(line_start), .frame_start(frame_start),
    .line_req(line_req), .line_req_y(line_req_y), .line_ack(line_ack),
    .underrun(underrun), .underrun_clr(underrun_clr)
  );

  always #5 clk = ~clk;

  function automatic int mx(int t); return t % HT; endfunction
  function automatic int my(int t); return t / HT; endfunction
  function automatic logic e_hs(int t);
    return !((mx(t) >= HA + HF) && (mx(t) < HA + HF + HS));
  endfunction
  function automatic logic e_vs(int t);
    return !((my(t) >= VA + VF) && (my(t) < VA + VF + VS));
  endfunction
  function automatic logic e_de(int t);
    return (mx(t) < HA) && (my(t) < VA);
  endfunction

  task automatic model_reset();
    m_t = FT - 1; m_req = 0; m_req_y = 0; m_und = 0; m_ls = 0; m_fs = 0;
  endtask

  task automatic step(input logic e, input logic a, input logic c);
    int nt, ny;
    logic set;
    en = e; line_ack = a; underrun_clr = c;
    @(posedge clk);
    nt = e ? (m_t + 1) % FT : m_t;
    set = 0;
    if (m_req) begin
      if (a) m_req = 0;
      else if (e && mx(nt) == 0 && my(nt) == m_req_y) begin m_req = 0; set = 1; end
    end else if (e && mx(nt) == HA) begin
      ny = (my(m_t) + 1) % VT;
      if (ny < VA) begin m_req = 1; m_req_y = ny; end
    end
    if (set) m_und = 1;
    else if (c) m_und = 0;
    m_ls = e && (mx(nt) == 0);
    m_fs = e && (nt == 0);
    m_t = nt;
    #1;
  endtask

  task automatic do_reset();
    en = 0; line_ack = 0; underrun_clr = 0;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (px_x !== 10'(HT - 1) || px_y !== 10'(VT - 1) || hsync !== 1'b1 || vsync !== 1'b1 ||
        de !== 1'b0 || line_start !== 1'b0 || frame_start !== 1'b0 || line_req !== 1'b0 ||
        line_req_y !== 10'd0 || underrun !== 1'b0) begin
      errors++;
      $display("FAIL reset_values got x=%0d y=%0d hs=%b vs=%b de=%b ls=%b fs=%b req=%b ry=%0d und=%b exp x=%0d y=%0d 1 1 0 0 0 0 0 0",
               px_x, px_y, hsync, vsync, de, line_start, frame_start, line_req, line_req_y, underrun, HT - 1, VT - 1);
    end
    step(1, 0, 0);
    checks++;
    if (px_x !== 10'd0 || px_y !== 10'd0 || frame_start !== 1'b1 || line_start !== 1'b1 || de !== 1'b1) begin
      errors++;
      $display("FAIL first_edge got x=%0d y=%0d fs=%b ls=%b de=%b exp 0 0 1 1 1", px_x, px_y, frame_start, line_start, de);
    end
  endtask

  task automatic test_timing();
    int hs_pulses = 0, hs_cyc = 0, vs_cyc = 0, de_cyc = 0, fs_cnt = 0, fs_first = -1, fs_gap = -1;
    int reqs = 0, bad_req_lines = 0, y0_req_y = -1;
    logic prev_hs = 1'b1, prev_req = 1'b0;
    do_reset();
    for (int i = 0; i < 2 * FT; i++) begin
      step(1, 1, 0);
      if (prev_hs && !hsync) hs_pulses++;
      if (!hsync) hs_cyc++;
      if (!vsync) vs_cyc++;
      if (de) de_cyc++;
      if (frame_start) begin
        if (fs_first < 0) fs_first = i; else if (fs_gap < 0) fs_gap = i - fs_first;
        fs_cnt++;
      end
      if (line_req && !prev_req) begin
        reqs++;
        if (int'(px_y) >= VA - 1 && int'(px_y) <= VT - 2) bad_req_lines++;
        if (int'(px_y) == VT - 1) y0_req_y = int'(line_req_y);
      end
      prev_hs = hsync; prev_req = line_req;
    end
    checks++; if (hs_pulses != 2 * VT) begin errors++; $display("FAIL hsync_pulses got %0d exp %0d", hs_pulses, 2 * VT); end
    checks++; if (hs_cyc != 2 * VT * HS) begin errors++; $display("FAIL hsync_cycles got %0d exp %0d", hs_cyc, 2 * VT * HS); end
    checks++; if (vs_cyc != 2 * VS * HT) begin errors++; $display("FAIL vsync_cycles got %0d exp %0d", vs_cyc, 2 * VS * HT); end
    checks++; if (de_cyc != 2 * HA * VA) begin errors++; $display("FAIL de_cycles got %0d exp %0d", de_cyc, 2 * HA * VA); end
    checks++; if (fs_cnt != 2 || fs_gap != FT) begin errors++; $display("FAIL frame_period got cnt=%0d gap=%0d exp 2 %0d", fs_cnt, fs_gap, FT); end
    checks++; if (reqs != 2 * VA) begin errors++; $display("FAIL req_count got %0d exp %0d", reqs, 2 * VA); end
    checks++; if (bad_req_lines != 0) begin errors++; $display("FAIL req_blank_lines got %0d exp 0", bad_req_lines); end
    checks++; if (y0_req_y != 0) begin errors++; $display("FAIL req_wrap_y got %0d exp 0", y0_req_y); end
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL timing_underrun got %b exp 0", underrun); end
  endtask

  task automatic test_underrun();
    int n;
    do_reset();
    n = 0;
    while (!line_req && n < 200) begin step(1, 0, 0); n++; end
    checks++;
    if (!line_req || px_x !== 10'(HA) || px_y !== 10'd0 || line_req_y !== 10'd1) begin
      errors++;
      $display("FAIL req_rise got req=%b x=%0d y=%0d ry=%0d exp 1 %0d 0 1", line_req, px_x, px_y, line_req_y, HA);
    end
    n = 0;
    while (line_req && n < 200) begin step(1, 0, 0); n++; end
    checks++;
    if (line_req || px_x !== 10'd0 || px_y !== 10'd1 || underrun !== 1'b1) begin
      errors++;
      $display("FAIL abandon got req=%b x=%0d y=%0d und=%b exp 0 0 1 1", line_req, px_x, px_y, underrun);
    end
    step(1, 0, 1);
    checks++;
    if (underrun !== 1'b0) begin errors++; $display("FAIL underrun_clr got %b exp 0", underrun); end
  endtask

  task automatic test_ack_latency();
    int n, high;
    do_reset();
    n = 0;
    while (!line_req && n < 200) begin step(1, 0, 0); n++; end
    high = 0;
    for (int i = 0; i < 4; i++) begin
      if (line_req) high++;
      step(1, 0, 0);
    end
    if (line_req) high++;
    step(1, 1, 0);
    checks++;
    if (high != 5 || line_req !== 1'b0 || underrun !== 1'b0) begin
      errors++;
      $display("FAIL ack_latency got high=%0d req=%b und=%b exp 5 0 0", high, line_req, underrun);
    end
  endtask

  task automatic test_freeze();
    int bad = 0, n;
    do_reset();
    for (int i = 0; i < 11; i++) step(1, 1, 0);
    for (int i = 0; i < 20; i++) begin
      step(0, 1, 0);
      if (px_x !== 10'd10 || px_y !== 10'd0 || de !== 1'b1 || line_start !== 1'b0 || frame_start !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL freeze_hold got %0d bad cycles exp 0", bad); end
    step(1, 1, 0);
    checks++; if (px_x !== 10'd11) begin errors++; $display("FAIL freeze_resume got %0d exp 11", px_x); end
    n = 0;
    do begin step(1, 1, 0); n++; end while (!frame_start && n < 2 * FT);
    checks++; if (n != FT - 11) begin errors++; $display("FAIL freeze_period got %0d exp %0d", n, FT - 11); end
  endtask

  task automatic test_rst_mid();
    do_reset();
    for (int i = 0; i < 5 * HT + 21; i++) step(1, 0, 0);
    checks++;
    if (px_x !== 10'd20 || px_y !== 10'd5 || line_req !== 1'b1) begin
      errors++;
      $display("FAIL pre_rst got x=%0d y=%0d req=%b exp 20 5 1", px_x, px_y, line_req);
    end
    #2 rst = 1;
    #1;
    checks++;
    if (px_x !== 10'(HT - 1) || px_y !== 10'(VT - 1) || line_req !== 1'b0 || line_req_y !== 10'd0 ||
        underrun !== 1'b0 || de !== 1'b0 || hsync !== 1'b1 || vsync !== 1'b1) begin
      errors++;
      $display("FAIL async_rst got x=%0d y=%0d req=%b ry=%0d und=%b de=%b hs=%b vs=%b exp %0d %0d 0 0 0 0 1 1",
               px_x, px_y, line_req, line_req_y, underrun, de, hsync, vsync, HT - 1, VT - 1);
    end
    @(posedge clk); #1;
    rst = 0;
    model_reset();
  endtask

  task automatic test_set_clr();
    do_reset();
    for (int i = 0; i < HT; i++) step(1, 0, 0);
    step(1, 0, 1);
    checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL set_beats_clr got %b exp 1", underrun); end
    step(1, 0, 1);
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL clr_after got %b exp 0", underrun); end
    for (int i = 0; i < HT - 2; i++) step(1, 0, 0);
    checks++; if (line_req !== 1'b1 || px_x !== 10'(HT - 1)) begin errors++; $display("FAIL pre_ack_abandon got req=%b x=%0d exp 1 %0d", line_req, px_x, HT - 1); end
    step(1, 1, 0);
    checks++;
    if (line_req !== 1'b0 || underrun !== 1'b0) begin
      errors++;
      $display("FAIL ack_beats_abandon got req=%b und=%b exp 0 0", line_req, underrun);
    end
  endtask

  task automatic test_random();
    logic e, a, c;
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      e = ($urandom_range(0, 9) != 0);
      a = ($urandom_range(0, 4) == 0);
      c = ($urandom_range(0, 19) == 0);
      step(e, a, c);
      checks++;
      if (int'(px_x) != mx(m_t) || int'(px_y) != my(m_t)) begin
        errors++; $display("FAIL rnd_pos cyc %0d got %0d,%0d exp %0d,%0d", i, px_x, px_y, mx(m_t), my(m_t));
      end
      checks++;
      if (hsync !== e_hs(m_t) || vsync !== e_vs(m_t) || de !== e_de(m_t)) begin
        errors++; $display("FAIL rnd_decode cyc %0d got %b%b%b exp %b%b%b", i, hsync, vsync, de, e_hs(m_t), e_vs(m_t), e_de(m_t));
      end
      checks++;
      if (line_start !== m_ls || frame_start !== m_fs) begin
        errors++; $display("FAIL rnd_pulses cyc %0d got ls=%b fs=%b exp %b %b", i, line_start, frame_start, m_ls, m_fs);
      end
      checks++;
      if (line_req !== m_req || underrun !== m_und || (m_req && int'(line_req_y) != m_req_y)) begin
        errors++; $display("FAIL rnd_hs cyc %0d got req=%b und=%b ry=%0d exp %b %b %0d", i, line_req, underrun, line_req_y, m_req, m_und, m_req_y);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_timing();
    test_underrun();
    test_ack_latency();
    test_freeze();
    test_rst_mid();
    test_set_clr();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
